wave_sequencer: RTL
===================

// Module: wave_sequencer
// PURPOSE
//  Playlist controller for the waveform generator: steps through a programmable table of
//  (wave select, dwell) entries and drives the generator's waveSelector. Also produces the
//  sample-rate tick (genEn) that paces the wave blocks, so one start plays a timed sequence.
// PARAMETERS
//  DEPTH    8   number of playlist entries (power of 2)
//  DWELL_W  16  width of per-entry dwell count, in genEn ticks
//  DIV_W    8   width of sample-rate divisor
// PORTS
//  clk          in   1               single system clock, rising edge
//  rst          in   1               asynchronous, active-high reset
//  cfgWe        in   1               write playlist entry cfgAddr this cycle
//  cfgAddr      in   log2(DEPTH)     entry index to write
//  cfgSel       in   3               wave code stored in entry (000..110)
//  cfgDwell     in   DWELL_W         dwell stored in entry; 0 treated as 1
//  numEntries   in   log2(DEPTH)+1   entries to play, latched at start; valid 1..DEPTH
//  divisor      in   DIV_W           genEn period = divisor+1 clocks, latched at start
//  loop         in   1               1: wrap to entry 0 after last; latched at start
//  start        in   1               begin playback (accepted only in IDLE)
//  stop         in   1               abort playback
//  waveSelector out  3               to generator; 3'b111 (output 0) when idle
//  genEn        out  1               one-clock sample tick for wave blocks
//  curIdx       out  log2(DEPTH)     entry currently playing
//  busy         out  1               high in LOAD/RUN
//  done         out  1               one-clock pulse on natural completion
// BEHAVIOUR
//  - Reset (async, immediate): state IDLE, waveSelector=3'b111, genEn=0, curIdx=0, busy=0,
//    done=0, dwell/divider counters 0. Playlist RAM not reset (contents undefined).
//  - All outputs decoded from registers; no combinational path input->output.
//  - FSM IDLE -> LOAD -> RUN -> (LOAD | FINISH) -> IDLE.
//  - IDLE: start=1 && 1<=numEntries<=DEPTH && stop=0 -> latch numEntries/divisor/loop,
//    curIdx=0, go LOAD. Otherwise (incl. numEntries 0 or >DEPTH) start ignored.
//  - LOAD (1 clk): busy=1, genEn=0; read entry[curIdx]; at edge: waveSelector<=sel,
//    dwellCnt<=max(dwell,1), divCnt<=0; go RUN.
//  - RUN: divCnt counts 0..divisor then wraps; genEn=1 while divCnt==divisor (divisor=0 ->
//    every clock). Each genEn decrements dwellCnt. On genEn with dwellCnt==1:
//    curIdx<numEntries-1 -> curIdx+1, LOAD; last entry & loop=1 -> curIdx=0, LOAD;
//    last entry & loop=0 -> FINISH.
//  - Entry cost: 1 LOAD clk + dwell*(divisor+1) RUN clks.
//  - FINISH (1 clk): done=1, busy=0, waveSelector=3'b111, genEn=0; go IDLE.
//  - stop=1 in LOAD/RUN/FINISH: next state IDLE, waveSelector=3'b111, genEn=0, busy=0,
//    no done pulse. stop beats a simultaneous final tick. start&stop in IDLE -> stay IDLE.
//  - start while busy ignored; latched params unchanged until next accepted start.
//  - cfgWe allowed any time; a write to an entry takes effect at its next LOAD. Write
//    and LOAD read of same entry in same clk: LOAD gets old contents.
//  - Rollover impossible: dwellCnt never decrements below 1, divCnt compared with ==.
// TESTING
//  1 Assert rst async mid-RUN (no clock edge) -> waveSelector=111, genEn/busy/done=0 at once.
//  2 entry0=(001,3), entry1=(010,2), numEntries=2, divisor=1, loop=0, start pulse ->
//    busy next clk for 12 clks: sel 001 w/ 3 genEn (every 2nd clk), LOAD, sel 010 w/ 2
//    genEn; then done=1 one clk, sel=111.
//  3 entry0=(011,0), numEntries=1, divisor=0, loop=1 -> sel stays 011, genEn alternates
//    0/1 (LOAD/RUN) indefinitely, done never; stop -> IDLE next clk, no done.
//  4 numEntries=0 and numEntries=9 with start -> busy stays 0; start during RUN -> no
//    restart, curIdx/counters undisturbed.
//  5 stop coincident with final genEn of last entry -> IDLE, done stays 0; start+stop
//    same clk in IDLE -> busy stays 0.
//  6 During RUN of entry0 rewrite entry1 via cfgWe to (101,1) -> LOAD of entry1 plays 101.

Source files
------------

// File: rtl/wave_sequencer.sv
// wave_sequencer
// Playlist controller for the waveform generator. A small table of
// (wave select, dwell) entries is written through the cfg port. A start
// request plays the entries in order. It drives waveSelector for each entry
// and holds it for dwell sample ticks. It also generates the genEn sample
// tick that paces the wave blocks.
//
// Ports:
//   clk, rst      system clock (rising edge), asynchronous active-high reset
//   cfgWe/cfgAddr/cfgSel/cfgDwell   playlist entry write port, usable any time
//   numEntries, divisor, loop       playback parameters, latched on an accepted start
//   start, stop   begin playback (only from idle) / abort playback
//   waveSelector  wave code to the generator, 3'b111 (silent) when not playing
//   genEn         one-clock sample tick, period divisor+1 clocks
//   curIdx        index of the entry being played
//   busy          high while loading or running an entry
//   done          one-clock pulse when a non-looping playlist completes
module wave_sequencer #(
    parameter int DEPTH   = 8,
    parameter int DWELL_W = 16,
    parameter int DIV_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfgWe,
    input  logic [$clog2(DEPTH)-1:0]   cfgAddr,
    input  logic [2:0]                 cfgSel,
    input  logic [DWELL_W-1:0]         cfgDwell,
    input  logic [$clog2(DEPTH):0]     numEntries,
    input  logic [DIV_W-1:0]           divisor,
    input  logic                       loop,
    input  logic                       start,
    input  logic                       stop,
    output logic [2:0]                 waveSelector,
    output logic                       genEn,
    output logic [$clog2(DEPTH)-1:0]   curIdx,
    output logic                       busy,
    output logic                       done
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);
    localparam logic [2:0]  SEL_OFF = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_FINISH
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           wsel_q, wsel_d;
    logic [AW-1:0]        curIdx_q, curIdx_d;
    logic [DWELL_W-1:0]   dwellCnt_q, dwellCnt_d;
    logic [DIV_W-1:0]     divCnt_q, divCnt_d;
    logic [AW:0]          numEnt_q, numEnt_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic                 loop_q, loop_d;

    logic [2:0]           selMem   [DEPTH];
    logic [DWELL_W-1:0]   dwellMem [DEPTH];

    logic                 tick;
    logic                 lastEntry;
    logic                 numValid;
    logic [DWELL_W-1:0]   memDwell;

    // The playlist RAM has no reset. A write and a LOAD read of the same entry
    // in the same clock give the LOAD the old contents, because the read happens
    // combinationally before this edge commits the write.
    always_ff @(posedge clk) begin
        if (cfgWe) begin
            selMem[cfgAddr]   <= cfgSel;
            dwellMem[cfgAddr] <= cfgDwell;
        end
    end

    assign tick      = (state_q == S_RUN) && (divCnt_q == div_q);
    assign lastEntry = ({1'b0, curIdx_q} == (numEnt_q - (AW+1)'(1)));
    assign numValid  = (numEntries != '0) && (numEntries <= DEPTH_N);
    assign memDwell  = dwellMem[curIdx_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wsel_q     <= SEL_OFF;
            curIdx_q   <= '0;
            dwellCnt_q <= '0;
            divCnt_q   <= '0;
            numEnt_q   <= '0;
            div_q      <= '0;
            loop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wsel_q     <= wsel_d;
            curIdx_q   <= curIdx_d;
            dwellCnt_q <= dwellCnt_d;
            divCnt_q   <= divCnt_d;
            numEnt_q   <= numEnt_d;
            div_q      <= div_d;
            loop_q     <= loop_d;
        end
    end

    // A stop is checked before the tick. This lets an abort win over a final
    // tick that arrives in the same clock. A dwell of 0 loads as 1. The dwell
    // counter therefore never goes below 1, and no rollover is possible.
    always_comb begin
        state_d    = state_q;
        wsel_d     = wsel_q;
        curIdx_d   = curIdx_q;
        dwellCnt_d = dwellCnt_q;
        divCnt_d   = divCnt_q;
        numEnt_d   = numEnt_q;
        div_d      = div_q;
        loop_d     = loop_q;
        case (state_q)
            S_IDLE: begin
                wsel_d = SEL_OFF;
                if (start && !stop && numValid) begin
                    numEnt_d = numEntries;
                    div_d    = divisor;
                    loop_d   = loop;
                    curIdx_d = '0;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                if (stop) begin
                    wsel_d  = SEL_OFF;
                    state_d = S_IDLE;
                end else begin
                    wsel_d     = selMem[curIdx_q];
                    dwellCnt_d = (memDwell == '0) ? DWELL_W'(1) : memDwell;
                    divCnt_d   = '0;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    wsel_d  = SEL_OFF;
                    state_d = S_IDLE;
                end else if (tick) begin
                    divCnt_d = '0;
                    if (dwellCnt_q == DWELL_W'(1)) begin
                        if (!lastEntry) begin
                            curIdx_d = curIdx_q + AW'(1);
                            state_d  = S_LOAD;
                        end else if (loop_q) begin
                            curIdx_d = '0;
                            state_d  = S_LOAD;
                        end else begin
                            wsel_d  = SEL_OFF;
                            state_d = S_FINISH;
                        end
                    end else begin
                        dwellCnt_d = dwellCnt_q - DWELL_W'(1);
                    end
                end else begin
                    divCnt_d = divCnt_q + DIV_W'(1);
                end
            end
            S_FINISH: begin
                wsel_d  = SEL_OFF;
                state_d = S_IDLE;
            end
            default: begin
                wsel_d  = SEL_OFF;
                state_d = S_IDLE;
            end
        endcase
    end

    // All outputs are decoded from registered state only.
    assign waveSelector = wsel_q;
    assign genEn        = tick;
    assign curIdx       = curIdx_q;
    assign busy         = (state_q == S_LOAD) || (state_q == S_RUN);
    assign done         = (state_q == S_FINISH);

endmodule
